// File: rtl/tri_pkg.sv
// Shared definitions for the triangle decoder: FSM states, default
// parameters and the 16-bit counter width.
// Optional feature macro used by this slice: TRIANGLE_DECODER_PERIOD_EN.
package tri_pkg;

  localparam int DEF_WIDTH  = 8;
  localparam int DEF_STEP   = 1;
  localparam int DEF_LOCK_N = 4;
  localparam int CNT_W      = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FIRST = 2'd1,
    RISE  = 2'd2,
    FALL  = 2'd3
  } state_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/tri_step_class.sv
// Classifies the step from prev to sample as UP (+STEP), DOWN (-STEP) or BAD.
// The difference is taken in WIDTH+1 signed arithmetic, so a wrap such as
// 0xFF -> 0x00 is a large negative step and therefore BAD.
module tri_step_class #(
  parameter int WIDTH = 8,
  parameter int STEP  = 1
) (
  input  logic [WIDTH-1:0] prev,
  input  logic [WIDTH-1:0] sample,
  output logic             up,
  output logic             down,
  output logic             bad
);

  localparam logic signed [WIDTH:0] STEP_POS = (WIDTH+1)'(STEP);
  localparam logic signed [WIDTH:0] STEP_NEG = (WIDTH+1)'(-STEP);

  logic signed [WIDTH:0] delta;

  // Zero-extend both operands so the subtraction never wraps.
  always_comb begin
    delta = $signed({1'b0, sample}) - $signed({1'b0, prev});
    up    = (delta == STEP_POS);
    down  = (delta == STEP_NEG);
    bad   = !(up || down);
  end

endmodule

// File: rtl/triangle_decoder.sv
// Triangle-wave stream decoder: tracks ramp direction, locks after LOCK_N
// consistent steps, flags top/bottom turnarounds and pattern violations,
// and counts completed periods.
// Define TRIANGLE_DECODER_PERIOD_EN to add the valley-to-valley sample
// counter that drives the period output; otherwise period is tied to 0.
module triangle_decoder
  import tri_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STEP   = DEF_STEP,
  parameter int LOCK_N = DEF_LOCK_N
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   in_data,
  output logic               dir,
  output logic               lock,
  output logic               peak_strobe,
  output logic               valley_strobe,
  output logic [WIDTH-1:0]   peak,
  output logic               err,
  output logic [CNT_W-1:0]   cycles,
  output logic [CNT_W-1:0]   period
);

  localparam int RUN_W = $clog2(LOCK_N + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(LOCK_N);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   prev_q, prev_d;
  logic [RUN_W-1:0]   run_q, run_d, run_inc;
  logic               dir_d, lock_d, peak_strobe_d, valley_strobe_d, err_d;
  logic [WIDTH-1:0]   peak_d;
  logic [CNT_W-1:0]   cycles_d;
  logic               step_up, step_down, step_bad;

  tri_step_class #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_step_class (
    .prev   (prev_q),
    .sample (in_data),
    .up     (step_up),
    .down   (step_down),
    .bad    (step_bad)
  );

  assign run_inc = (run_q == RUN_MAX) ? run_q : run_q + 1'b1;

  // Next-state and next-output decode for one accepted sample.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    state_d         = state_q;
    prev_d          = prev_q;
    run_d           = run_q;
    dir_d           = dir;
    lock_d          = lock;
    peak_d          = peak;
    cycles_d        = cycles;
    peak_strobe_d   = 1'b0;
    valley_strobe_d = 1'b0;
    err_d           = 1'b0;

    if (in_valid) begin
      prev_d = in_data;
      unique case (state_q)
        IDLE: state_d = FIRST;
        FIRST: begin
          if (step_up) begin
            state_d = RISE;
            dir_d   = 1'b1;
            run_d   = RUN_W'(1);
          end else if (step_down) begin
            state_d = FALL;
            dir_d   = 1'b0;
            run_d   = RUN_W'(1);
          end else begin
            err_d = 1'b1;
          end
        end
        RISE: begin
          if (!step_bad) begin
            run_d = run_inc;
            if (step_down) begin
              state_d       = FALL;
              dir_d         = 1'b0;
              peak_d        = prev_q;
              peak_strobe_d = 1'b1;
            end
          end
        end
        FALL: begin
          if (!step_bad) begin
            run_d = run_inc;
            if (step_up) begin
              state_d         = RISE;
              dir_d           = 1'b1;
              valley_strobe_d = 1'b1;
              if (lock) cycles_d = sat_inc(cycles);
            end
          end
        end
        default: state_d = IDLE;
      endcase

      // A broken ramp drops back to FIRST and restarts acquisition.
      if ((state_q == RISE || state_q == FALL) && step_bad) begin
        err_d   = 1'b1;
        lock_d  = 1'b0;
        run_d   = '0;
        dir_d   = 1'b0;
        state_d = FIRST;
      end

      if (!err_d && run_d == RUN_MAX) lock_d = 1'b1;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst) begin
      state_q       <= IDLE;
      prev_q        <= '0;
      run_q         <= '0;
      dir           <= 1'b0;
      lock          <= 1'b0;
      peak_strobe   <= 1'b0;
      valley_strobe <= 1'b0;
      err           <= 1'b0;
      peak          <= '0;
      cycles        <= '0;
    end else begin
      state_q       <= state_d;
      prev_q        <= prev_d;
      run_q         <= run_d;
      dir           <= dir_d;
      lock          <= lock_d;
      peak_strobe   <= peak_strobe_d;
      valley_strobe <= valley_strobe_d;
      err           <= err_d;
      peak          <= peak_d;
      cycles        <= cycles_d;
    end
  end

`ifdef TRIANGLE_DECODER_PERIOD_EN
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] period_q;
  logic             cnt_run_q;

  // Valley-to-valley sample counter; a violation stops it until the next valley.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      period_q  <= '0;
      cnt_run_q <= 1'b0;
    end else if (in_valid) begin
      if (err_d) begin
        cnt_q     <= '0;
        cnt_run_q <= 1'b0;
      end else if (valley_strobe_d) begin
        if (cnt_run_q) period_q <= sat_inc(cnt_q);
        cnt_q     <= '0;
        cnt_run_q <= 1'b1;
      end else if (cnt_run_q) begin
        cnt_q <= sat_inc(cnt_q);
      end
    end
  end

  assign period = period_q;
`else
  assign period = '0;
`endif

endmodule

// File: doc/triangle_decoder.md
TRIANGLE_DECODER -- requirements
Module: triangle_decoder

Interface
REQ-001 Parameter WIDTH, default 8: sample width in bits.
REQ-002 Parameter STEP, default 1: expected absolute difference between consecutive samples.
REQ-003 Parameter LOCK_N, default 4: consecutive valid steps required to assert lock.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  in_data carries a sample this cycle.
REQ-007 in_data  input  WIDTH  sample from a triangular counter stream.
REQ-008 dir  output  1  1 = currently rising, 0 = falling or unknown.
REQ-009 lock  output  1  stream has matched the triangle pattern for at least LOCK_N steps.
REQ-010 peak_strobe  output  1  one-cycle pulse on a top turnaround.
REQ-011 valley_strobe  output  1  one-cycle pulse on a bottom turnaround.
REQ-012 peak  output  WIDTH  value of the most recent top sample.
REQ-013 err  output  1  one-cycle pulse on a pattern violation.
REQ-014 cycles  output  16  count of completed periods (valley turnarounds while locked), saturating.
REQ-015 period  output  16  valid samples between the last two valley turnarounds (see REQ-032).

Function
REQ-016 All outputs are registered and respond one clk after the accepted in_valid sample; nothing changes when in_valid=0.
REQ-017 delta = in_data - prev, computed in WIDTH+1 signed arithmetic with no wrap-around; a 0xFF->0x00 transition is a violation.
REQ-018 States: IDLE (no sample), FIRST (one sample held), RISE, FALL.
REQ-019 IDLE: valid sample -> prev<=in_data, go to FIRST, no strobes.
REQ-020 FIRST: delta=+STEP -> RISE, dir<=1, run<=1; delta=-STEP -> FALL, dir<=0, run<=1; any other delta -> err, stay in FIRST.
REQ-021 RISE: delta=+STEP -> stay, run++; delta=-STEP -> FALL, peak<=prev, peak_strobe, run++.
REQ-022 FALL: delta=-STEP -> stay, run++; delta=+STEP -> RISE, valley_strobe, run++, and cycles++ if lock=1.
REQ-023 RISE or FALL with any other delta (including 0) -> err pulse, lock<=0, run<=0, dir<=0, go to FIRST.
REQ-024 prev<=in_data on every accepted sample, including violating samples.
REQ-025 lock<=1 when run reaches LOCK_N; run saturates at LOCK_N.
REQ-026 cycles saturates at 0xFFFF; it is cleared only by rst.
REQ-027 peak retains its value across err; it is cleared only by rst.
REQ-028 peak_strobe, valley_strobe and err are mutually exclusive in any cycle.

Reset
REQ-029 rst=1 -> state=IDLE, prev=0, run=0, and dir, lock, peak_strobe, valley_strobe, err, peak, cycles and period all 0.
REQ-030 rst takes priority over in_valid; the sample presented in the reset cycle is discarded.
REQ-031 Reset asserted mid-ramp restarts acquisition from IDLE; no strobe or err is emitted in that cycle.

Configuration
REQ-032 With TRIANGLE_DECODER_PERIOD_EN defined, a 16-bit saturating sample counter runs from each valley_strobe; on the next valley_strobe, period<=count and the counter restarts; err clears the counter without updating period.
REQ-033 Without TRIANGLE_DECODER_PERIOD_EN, the period output is tied to 0 and no counter logic is synthesised.

Structure
REQ-034 Package tri_pkg holds the state enumeration (IDLE, FIRST, RISE, FALL), the default STEP, LOCK_N and WIDTH constants, and the 16-bit counter width.
REQ-035 Sub-module tri_step_class classifies delta as UP, DOWN or BAD from prev, in_data and STEP; triangle_decoder instantiates it once.

Verification
REQ-036 Samples 0,1,2,3,4,5,4,3 (STEP=1) -> lock=1 after sample 4; peak_strobe with peak=5 on sample 4 after the top; dir goes 1 then 0.
REQ-037 Samples 0..3,2,1,0,1,2 with lock set -> valley_strobe on the rising 1 after 0; cycles=1.
REQ-038 Samples 2,3,3 -> err pulse on the repeated 3; lock=0; state FIRST; next 4 -> RISE.
REQ-039 Samples 254,255,0 -> err on 0; no wrap accepted.
REQ-040 Reset asserted during a locked ramp at sample 7 -> all outputs 0 the next cycle; next sample enters FIRST only.
REQ-041 With TRIANGLE_DECODER_PERIOD_EN and a full 0->3->0 triangle repeated -> period=6 after the second valley_strobe; in_valid gaps do not change period.
